btn_pulse_shaper: RTL
=====================

// Module: btn_pulse_shaper
// PURPOSE
//   Debounces one raw active-low pushbutton and emits exactly one CLK-wide
//   pulse per accepted press. Sits directly upstream of the 4-bit event
//   counter: pulse_out drives the counter's sig_in, so one physical press
//   gives one count. Also provides a debounced level (held) for display/LEDs.
// PARAMETERS
//   DB_CYCLES  4  consecutive stable synchronized samples required after entry
//                 to a debounce state; legal range 1..2**CNT_W
//   CNT_W      8  debounce counter width
// PORTS
//   CLK        in   1      system clock, all logic on rising edge
//   RST        in   1      synchronous, active-low reset
//   btn_n      in   1      raw asynchronous button, 0 = pressed
//   pulse_out  out  1      single-cycle press pulse (to counter sig_in)
//   held       out  1      debounced pressed level
//   state_dbg  out  3      current FSM state encoding (verification visibility)
// BEHAVIOUR
//   Reset (RST==0 at a rising edge): sync1=sync2=1, state=S_IDLE, cnt=0;
//     pulse_out=0, held=0, state_dbg=3'd0. Reset overrides all other events.
//   Sync: btn_n -> sync1 -> sync2 (2 flops). The FSM reads only sync2.
//   States/encoding: S_IDLE=0, S_DB_PRESS=1, S_PULSE=2, S_HELD=3, S_DB_REL=4.
//   Unused codes 5..7 go to S_IDLE on the next edge.
//   Transitions (evaluated every rising edge):
//     S_IDLE:     sync2==0 -> S_DB_PRESS with cnt=0; else stay.
//     S_DB_PRESS: sync2==1 -> S_IDLE with cnt=0 (bounce rejected);
//                 sync2==0 and cnt==DB_CYCLES-1 -> S_PULSE with cnt=0;
//                 else cnt<=cnt+1.
//     S_PULSE:    always -> S_HELD (unconditional, one cycle only).
//     S_HELD:     sync2==1 -> S_DB_REL with cnt=0; else stay.
//     S_DB_REL:   sync2==0 -> S_HELD with cnt=0 (release bounce, no pulse);
//                 sync2==1 and cnt==DB_CYCLES-1 -> S_IDLE with cnt=0;
//                 else cnt<=cnt+1.
//   Outputs are Moore, decoded from the state register:
//     pulse_out=1 only in S_PULSE; held=1 in S_PULSE, S_HELD and S_DB_REL.
//   Latency: with btn_n held low, pulse_out is high for the cycle following
//     the (DB_CYCLES+3)th rising edge, counting the first edge that samples
//     btn_n=0 as edge 1 (7th edge for DB_CYCLES=4).
//   Press acceptance: requires DB_CYCLES+1 consecutive sync2==0 samples
//     (the S_IDLE sample plus DB_CYCLES samples in S_DB_PRESS).
//   Release: held falls after DB_CYCLES+1 consecutive sync2==1 samples.
//   Constraints: cnt never exceeds DB_CYCLES-1 and never wraps.
//   Exactly one pulse per press; a long hold never re-pulses.
//   Reset mid-press: the block returns to S_IDLE. If the button is still
//     down after RST deasserts, it is treated as a new press and pulses once.
// TESTING
//   1 Reset: RST=0 for 3 edges, btn_n=0 -> pulse_out=0, held=0, state_dbg=0.
//   2 Clean press, DB_CYCLES=4: btn_n 1->0 held 20 cycles -> exactly one
//     pulse_out, on the 7th edge after the first low sample; held=1 from then.
//   3 Bounce: btn_n low for 3 cycles, high 1, low 2, high -> no pulse_out,
//     held stays 0, FSM returns to state_dbg=0.
//   4 Release bounce: from S_HELD, btn_n high 2, low 1, high 10 -> no second
//     pulse; held returns to 0 after 5 consecutive high sync2 samples.
//   5 Counter integration: 5 clean presses into the 4-bit counter -> count
//     goes 0->5; 17 presses -> count wraps to 1.
//   6 Reset mid-hold: assert RST in S_HELD with btn_n=0, then release RST ->
//     outputs 0 during reset, then exactly one new pulse after 7 edges.

Source files
------------

// File: rtl/btn_pulse_shaper.sv
// Debounced active-low pushbutton front end: two-flop synchronizer, press/release
// debounce FSM, one CLK-wide pulse per accepted press plus a debounced held level.
module btn_pulse_shaper #(
  parameter int DB_CYCLES = 4,
  parameter int CNT_W     = 8
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       btn_n,
  output logic       pulse_out,
  output logic       held,
  output logic [2:0] state_dbg
);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DB_PRESS = 3'd1,
    S_PULSE    = 3'd2,
    S_HELD     = 3'd3,
    S_DB_REL   = 3'd4
  } state_e;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             sync1_q, sync2_q;
  logic             pulse_q, pulse_d;
  logic             held_q, held_d;

  // Next-state and debounce counter; codes 5..7 fall through to idle.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: begin
        if (!sync2_q) begin
          state_d = S_DB_PRESS;
          cnt_d   = '0;
        end else begin
          state_d = S_IDLE;
          cnt_d   = cnt_q;
        end
      end
      S_DB_PRESS: begin
        if (sync2_q) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_PULSE;
          cnt_d   = '0;
        end else begin
          state_d = S_DB_PRESS;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      S_PULSE: begin
        state_d = S_HELD;
        cnt_d   = cnt_q;
      end
      S_HELD: begin
        if (sync2_q) begin
          state_d = S_DB_REL;
          cnt_d   = '0;
        end else begin
          state_d = S_HELD;
          cnt_d   = cnt_q;
        end
      end
      S_DB_REL: begin
        if (!sync2_q) begin
          state_d = S_HELD;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          state_d = S_DB_REL;
          cnt_d   = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so the registered copies track state_q.
  always_comb begin
    pulse_d = (state_d == S_PULSE);
    held_d  = (state_d == S_PULSE) || (state_d == S_HELD) || (state_d == S_DB_REL);
  end

  // Synchronizer, FSM state, counter and output registers.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      state_q <= S_IDLE;
      cnt_q   <= '0;
      pulse_q <= 1'b0;
      held_q  <= 1'b0;
    end else begin
      sync1_q <= btn_n;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pulse_q <= pulse_d;
      held_q  <= held_d;
    end
  end

  assign pulse_out = pulse_q;
  assign held      = held_q;
  assign state_dbg = state_q;

endmodule
